// File: rtl/led_sequence_counter.sv
// LED pattern generator with a runtime prescaler, four sequence modes
// (binary up/down, Gray, Johnson) and a run/hold control with single-step.
module led_sequence_counter #(
    parameter int WIDTH     = 10,
    parameter int DIV_WIDTH = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [1:0]           mode,
    input  logic                 run,
    input  logic                 step,
    output logic [WIDTH-1:0]     count,
    output logic                 tick,
    output logic                 wrap
);

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_GRAY    = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    localparam logic [WIDTH-1:0] IDX_ALL_ONES     = '1;
    localparam logic [WIDTH-1:0] IDX_ZERO         = '0;
    localparam logic [WIDTH-1:0] IDX_JOHNSON_LAST = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]     idx_reg;
    logic [DIV_WIDTH-1:0] pre_reg;
    logic [1:0]           mode_reg;
    logic                 step_reg;
    logic                 tick_reg;
    logic                 wrap_reg;

    logic [DIV_WIDTH-1:0] div_eff;
    logic                 pre_hit;
    logic                 step_edge;
    logic                 adv;
    logic                 mode_change;
    logic                 wrap_cond;
    logic [WIDTH-1:0]     idx_next;
    logic [WIDTH-1:0]     gray;

    // Comparing with >= lets a divisor lowered mid-count fire immediately.
    always_comb begin
        div_eff     = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
        pre_hit     = run && (pre_reg >= (div_eff - DIV_WIDTH'(1)));
        step_edge   = step && !step_reg;
        adv         = pre_hit || (step_edge && !run);
        mode_change = (mode != mode_reg);
    end

    always_comb begin
        idx_next  = idx_reg;
        wrap_cond = 1'b0;
        case (mode_reg)
            MODE_UP, MODE_GRAY: begin
                idx_next  = idx_reg + WIDTH'(1);
                wrap_cond = (idx_reg == IDX_ALL_ONES);
            end
            MODE_DOWN: begin
                idx_next  = idx_reg - WIDTH'(1);
                wrap_cond = (idx_reg == IDX_ZERO);
            end
            MODE_JOHNSON: begin
                idx_next  = {idx_reg[WIDTH-2:0], ~idx_reg[WIDTH-1]};
                wrap_cond = (idx_reg == IDX_JOHNSON_LAST);
            end
            default: begin
                idx_next  = idx_reg;
                wrap_cond = 1'b0;
            end
        endcase
    end

    // A mode switch restarts the sequence and swallows any advance that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg  <= '0;
            pre_reg  <= '0;
            mode_reg <= mode;
            step_reg <= 1'b1;
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            step_reg <= step;
            if (mode_change) begin
                idx_reg  <= '0;
                pre_reg  <= '0;
                mode_reg <= mode;
                tick_reg <= 1'b0;
                wrap_reg <= 1'b0;
            end else begin
                if (!run || pre_hit) begin
                    pre_reg <= '0;
                end else begin
                    pre_reg <= pre_reg + DIV_WIDTH'(1);
                end
                tick_reg <= adv;
                wrap_reg <= adv && wrap_cond;
                if (adv) begin
                    idx_reg <= idx_next;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray[gi] = idx_reg[gi] ^ idx_reg[gi+1];
        end
    endgenerate
    assign gray[WIDTH-1] = idx_reg[WIDTH-1];

    assign count = (mode_reg == MODE_GRAY) ? gray : idx_reg;
    assign tick  = tick_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_led_sequence_counter.sv
// Self-checking bench for led_sequence_counter (WIDTH=4): a cycle model pushes
// expected {count,tick,wrap} to a queue that is popped after every clock edge.
module tb_led_sequence_counter;

    localparam int W  = 4;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] divisor;
    logic [1:0]    mode;
    logic          run;
    logic          step;
    logic [W-1:0]  count;
    logic          tick;
    logic          wrap;

    led_sequence_counter #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .divisor (divisor),
        .mode    (mode),
        .run     (run),
        .step    (step),
        .count   (count),
        .tick    (tick),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;

    logic [5:0] sb_q [$];
    logic [3:0] seq_q [$];

    // Reference model state
    logic [3:0] m_idx;
    int         m_pre;
    logic [1:0] m_mode;
    logic       m_stepq;
    logic       m_tick;
    logic       m_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_display(input logic [3:0] v, input logic [1:0] md);
        logic [3:0] g;
        g[3] = v[3];
        for (int i = 0; i < 3; i++) g[i] = v[i] ^ v[i+1];
        return (md == 2'b10) ? g : v;
    endfunction

    task automatic model_step();
        int         d;
        logic       fire, sedge, adv;
        logic [3:0] nidx;
        if (reset) begin
            m_idx = 0; m_pre = 0; m_mode = mode; m_stepq = 1; m_tick = 0; m_wrap = 0;
        end else begin
            d     = (divisor == 0) ? 1 : int'(divisor);
            fire  = run && (m_pre + 1 >= d);
            sedge = step && !m_stepq;
            adv   = fire || (sedge && !run);
            if (mode != m_mode) begin
                m_idx = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_mode = mode;
            end else begin
                m_pre  = (!run || fire) ? 0 : m_pre + 1;
                m_tick = adv;
                m_wrap = 0;
                if (adv) begin
                    case (m_mode)
                        2'b01:   nidx = m_idx - 4'd1;
                        2'b11:   nidx = {m_idx[2:0], ~m_idx[3]};
                        default: nidx = m_idx + 4'd1;
                    endcase
                    // wrap means landing back on the sequence's start value
                    m_wrap = (m_mode == 2'b01) ? (nidx == 4'hF) : (nidx == 4'h0);
                    m_idx  = nidx;
                end
            end
            m_stepq = step;
        end
        sb_q.push_back({exp_display(m_idx, m_mode), m_tick, m_wrap});
    endtask

    task automatic cycle();
        logic [5:0] exp;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        exp = sb_q.pop_front();
        $display("cyc=%0d rst=%0b mode=%0d run=%0b step=%0b div=%0d count=%b tick=%0b wrap=%0b",
                 cyc, reset, mode, run, step, divisor, count, tick, wrap);
        check("scoreboard", {26'd0, count, tick, wrap}, {26'd0, exp});
        if (tick) begin
            tick_cnt++;
            seq_q.push_back(count);
        end
        if (wrap) wrap_cnt++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_stats();
        tick_cnt = 0;
        wrap_cnt = 0;
        seq_q.delete();
    endtask

    logic [3:0] gray_exp [8];
    logic [3:0] john_exp [8];
    logic [3:0] prev;

    initial begin
        gray_exp = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        john_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

        // Up count, D=3
        reset = 1; divisor = 3; mode = 2'b00; run = 1; step = 0;
        cycles(2);
        check("reset_count", {28'd0, count}, 32'd0);
        reset = 0;
        clear_stats();
        cycles(48);
        check("up_ticks", tick_cnt, 16);
        check("up_wraps", wrap_cnt, 1);
        check("up_first", {28'd0, seq_q[0]}, 32'd1);
        check("up_last", {28'd0, seq_q[15]}, 32'd0);

        // Down, D=1
        divisor = 1; mode = 2'b01;
        clear_stats();
        cycles(17);
        check("down_ticks", tick_cnt, 16);
        check("down_wraps", wrap_cnt, 1);
        check("down_first", {28'd0, seq_q[0]}, 32'd15);

        // Gray
        mode = 2'b10;
        clear_stats();
        cycles(9);
        check("gray_ticks", tick_cnt, 8);
        prev = 4'd0;
        for (int i = 0; i < 8 && i < seq_q.size(); i++) begin
            check("gray_seq", {28'd0, seq_q[i]}, {28'd0, gray_exp[i]});
            check("gray_onebit", $countones(seq_q[i] ^ prev), 1);
            prev = seq_q[i];
        end

        // Johnson
        mode = 2'b11;
        clear_stats();
        cycles(9);
        check("john_wraps", wrap_cnt, 1);
        for (int i = 0; i < 8 && i < seq_q.size(); i++)
            check("john_seq", {28'd0, seq_q[i]}, {28'd0, john_exp[i]});

        // Step held for 10 cycles with run=0
        reset = 1; mode = 2'b00; run = 0; divisor = 5; step = 0;
        cycles(2);
        reset = 0;
        cycles(2);
        clear_stats();
        step = 1;
        cycles(10);
        step = 0;
        cycles(3);
        check("step_hold_ticks", tick_cnt, 1);

        // Step held through reset release
        reset = 1; step = 1;
        cycles(2);
        reset = 0;
        clear_stats();
        cycles(5);
        check("step_reset_ticks", tick_cnt, 0);
        step = 0;
        cycles(1);

        // run=1 with step pulses: only prescaler advances
        run = 1;
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            cycle();
        end
        step = 0;
        check("run_step_ticks", tick_cnt, 4);

        // Mode change 00 -> 11 at count=9
        reset = 1; mode = 2'b00; run = 1; divisor = 1;
        cycles(1);
        reset = 0;
        cycles(9);
        check("pre_mchg_count", {28'd0, count}, 32'd9);
        mode = 2'b11;
        cycles(1);
        check("mchg_count", {28'd0, count}, 32'd0);
        check("mchg_tick", {31'd0, tick}, 32'd0);
        cycles(2);
        check("mchg_john", {28'd0, count}, 32'b0011);

        // Divisor cut from 1000 to 2 at pre=500
        reset = 1; mode = 2'b00; divisor = 1000;
        cycles(1);
        reset = 0;
        cycles(500);
        check("cut_no_tick", {28'd0, count}, 32'd0);
        divisor = 2;
        cycles(1);
        check("cut_tick", {31'd0, tick}, 32'd1);
        clear_stats();
        cycles(6);
        check("cut_ticks", tick_cnt, 3);

        // divisor=0 behaves as 1
        divisor = 0;
        cycles(1);
        clear_stats();
        cycles(5);
        check("div0_ticks", tick_cnt, 5);

        // Reset mid-operation with a tick due on the reset edge
        reset = 1; divisor = 3;
        cycles(1);
        reset = 0;
        cycles(23);
        check("pre_rst_count", {28'd0, count}, 32'd7);
        reset = 1;
        cycles(1);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        reset = 0;
        clear_stats();
        cycles(2);
        check("rst_quiet", tick_cnt, 0);
        cycles(1);
        check("rst_first_tick", {31'd0, tick}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
